accel_tilt_filter: RTL and testbench
====================================

Name: accel_tilt_filter

Overview:
- Sits directly downstream of the SPI accelerometer reader; consumes its per-axis Y/Z sample words plus a one-cycle sample strobe.
- Smooths each axis with a power-of-two moving-average window.
- Classifies the board's attitude (flat / tilted right / tilted left, upside-down) with hysteresis for the LED/display logic.

Parameters:
- LOG2_WIN, 3, log2 of moving-average window length (window WIN = 2^LOG2_WIN samples, legal 1..5).
- THRESH, 200, signed magnitude of y_avg (LSB counts) that enters a tilt state.
- HYST, 50, hysteresis counts; a tilt state exits when |y_avg| drops to THRESH-HYST or below.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- sample_valid  input  1  one-cycle strobe; Y_value/Z_value hold a new sample pair.
- Y_value  input  16  Y axis sample, two's complement.
- Z_value  input  16  Z axis sample, two's complement.
- clear  input  1  synchronous flush of window, averages and tilt state.
- y_avg  output  16  filtered Y, two's complement.
- z_avg  output  16  filtered Z, two's complement.
- avg_valid  output  1  one-cycle pulse, y_avg/z_avg updated and window full.
- tilt  output  2  00 flat, 01 right (y positive), 10 left (y negative); 11 never driven.
- upside_down  output  1  1 while z_avg < 0.

Behaviour:
- Reset (async, any cycle incl. mid-window): y_avg=0, z_avg=0, avg_valid=0, tilt=00, upside_down=0, sums=0, fill count=0, write pointer=0, buffer contents don't-care (masked by fill count).
- Storage: one circular buffer per axis, WIN entries x 16 bits, shared write pointer wrapping WIN-1 -> 0.
- Sums: signed, 16+LOG2_WIN bits; inputs sign-extended. No overflow possible by construction.
- Stage 1 (edge sampling sample_valid=1): write sample at pointer, pointer+1 mod WIN. If fill<WIN: sum += new, fill+1. Else: sum += new - entry being overwritten (read before write, same edge).
- Stage 2 (next edge): y_avg/z_avg <= sum >>> LOG2_WIN (arithmetic, floors toward minus infinity); avg_valid=1 for exactly this cycle only if fill==WIN after stage 1. During warm-up (fill<WIN) averages are not updated and avg_valid stays 0.
- Latency: sample_valid at edge n -> avg_valid high in cycle after edge n+1; tilt/upside_down update at edge n+2.
- Back-to-back sample_valid every cycle supported with no loss; avg_valid pulses every cycle once full.
- Tilt FSM (FLAT, RIGHT, LEFT), evaluated only on the edge where avg_valid=1, signed compares on y_avg:
  - FLAT: y_avg > THRESH -> RIGHT; y_avg < -THRESH -> LEFT; else stay.
  - RIGHT: y_avg <= THRESH-HYST -> FLAT (even if < -THRESH, go FLAT first).
  - LEFT: y_avg >= -(THRESH-HYST) -> FLAT.
  - Exactly equal to THRESH does not enter a tilt state.
- upside_down <= (z_avg[15]) on same edge as tilt evaluation.
- clear=1: fill=0, sums=0, pointer=0, y_avg=z_avg=0, avg_valid=0, tilt=FLAT, upside_down=0 at that edge; in-flight stage-2 result discarded. clear and sample_valid together: clear wins, sample dropped.

Test Plan:
- Warm-up: 8 strobes of Y=16'h0100, Z=16'h0040, 3 idle cycles apart -> avg_valid 0 through 7th; one pulse two edges after 8th with y_avg=16'h0100, z_avg=16'h0040.
- Sliding window: after above, 8 back-to-back strobes Y=16'h0000 -> y_avg steps 0x00E0,0x00C0,...,0x0000 on consecutive cycles, avg_valid high 8 cycles.
- Negative floor: window of seven Y=0 and one Y=16'hFFFF -> y_avg=16'hFFFF; all Y=16'hFFF8 -> y_avg=16'hFFF8; Z=16'hFF00 -> upside_down=1.
- Hysteresis: y_avg 201 -> tilt 01; 160 -> stays 01; 150 -> 00; 200 -> stays 00; -201 -> 10; -151 -> stays 10; -150 -> 00.
- Clear with simultaneous sample_valid mid-window -> outputs zero, tilt 00, next avg_valid only after 8 further samples.
- Async reset asserted between clock edges mid-stream -> all outputs 0 immediately, no avg_valid until 8 new samples after release.

Source files
------------

// File: rtl/accel_tilt_filter.sv
// Moving-average filter for the Y/Z accelerometer axes, with a hysteretic
// flat/right/left tilt classifier and an upside-down flag driven from the averages.
module accel_tilt_filter #(
    parameter int LOG2_WIN = 3,
    parameter int THRESH   = 200,
    parameter int HYST     = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] Y_value,
    input  logic [15:0] Z_value,
    input  logic        clear,
    output logic [15:0] y_avg,
    output logic [15:0] z_avg,
    output logic        avg_valid,
    output logic [1:0]  tilt,
    output logic        upside_down
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = 16 + LOG2_WIN;

    localparam logic [LOG2_WIN:0]   FILL_FULL = (LOG2_WIN + 1)'(WIN);
    localparam logic [LOG2_WIN:0]   FILL_ONE  = (LOG2_WIN + 1)'(1);
    localparam logic [LOG2_WIN-1:0] PTR_ONE   = LOG2_WIN'(1);

    localparam logic signed [15:0] ENTER_POS = 16'(THRESH);
    localparam logic signed [15:0] ENTER_NEG = 16'(-THRESH);
    localparam logic signed [15:0] EXIT_POS  = 16'(THRESH - HYST);
    localparam logic signed [15:0] EXIT_NEG  = 16'(-(THRESH - HYST));

    typedef enum logic [1:0] {
        ST_FLAT  = 2'b00,
        ST_RIGHT = 2'b01,
        ST_LEFT  = 2'b10
    } tilt_state_t;

    logic [15:0]          r_buf_y [WIN];
    logic [15:0]          r_buf_z [WIN];
    logic [LOG2_WIN-1:0]  r_wptr;
    logic [LOG2_WIN:0]    r_fill;
    logic signed [SW-1:0] r_y_sum;
    logic signed [SW-1:0] r_z_sum;
    logic                 r_pend;
    logic signed [15:0]   r_y_avg;
    logic signed [15:0]   r_z_avg;
    logic                 r_avg_valid;
    tilt_state_t          r_state;
    logic                 r_upside;

    logic                 w_take;
    logic                 w_full;
    logic signed [SW-1:0] w_y_new;
    logic signed [SW-1:0] w_z_new;
    logic signed [SW-1:0] w_y_old;
    logic signed [SW-1:0] w_z_old;
    logic signed [SW-1:0] w_y_sum_nxt;
    logic signed [SW-1:0] w_z_sum_nxt;

    // A clear on the same edge as a strobe drops that sample entirely.
    assign w_take  = sample_valid && !clear;
    assign w_full  = (r_fill == FILL_FULL);
    assign w_y_new = {{LOG2_WIN{Y_value[15]}}, Y_value};
    assign w_z_new = {{LOG2_WIN{Z_value[15]}}, Z_value};
    assign w_y_old = {{LOG2_WIN{r_buf_y[r_wptr][15]}}, r_buf_y[r_wptr]};
    assign w_z_old = {{LOG2_WIN{r_buf_z[r_wptr][15]}}, r_buf_z[r_wptr]};

    always_comb begin
        w_y_sum_nxt = r_y_sum + w_y_new;
        w_z_sum_nxt = r_z_sum + w_z_new;
        if (w_full) begin
            w_y_sum_nxt = r_y_sum + w_y_new - w_y_old;
            w_z_sum_nxt = r_z_sum + w_z_new - w_z_old;
        end
    end

    // Buffer contents are never reset; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_buf_y[r_wptr] <= Y_value;
            r_buf_z[r_wptr] <= Z_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_fill      <= '0;
            r_y_sum     <= '0;
            r_z_sum     <= '0;
            r_pend      <= 1'b0;
            r_y_avg     <= '0;
            r_z_avg     <= '0;
            r_avg_valid <= 1'b0;
            r_state     <= ST_FLAT;
            r_upside    <= 1'b0;
        end else if (clear) begin
            r_wptr      <= '0;
            r_fill      <= '0;
            r_y_sum     <= '0;
            r_z_sum     <= '0;
            r_pend      <= 1'b0;
            r_y_avg     <= '0;
            r_z_avg     <= '0;
            r_avg_valid <= 1'b0;
            r_state     <= ST_FLAT;
            r_upside    <= 1'b0;
        end else begin
            if (w_take) begin
                r_y_sum <= w_y_sum_nxt;
                r_z_sum <= w_z_sum_nxt;
                r_wptr  <= r_wptr + PTR_ONE;
                if (!w_full) begin
                    r_fill <= r_fill + FILL_ONE;
                end
            end
            r_pend      <= w_take && (w_full || (r_fill == FILL_FULL - FILL_ONE));
            r_avg_valid <= r_pend;
            // Taking the upper 16 bits is an arithmetic shift that floors toward -inf.
            if (r_pend) begin
                r_y_avg <= r_y_sum[SW-1:LOG2_WIN];
                r_z_avg <= r_z_sum[SW-1:LOG2_WIN];
            end
            if (r_avg_valid) begin
                r_upside <= r_z_avg[15];
                case (r_state)
                    ST_FLAT: begin
                        if (r_y_avg > ENTER_POS) begin
                            r_state <= ST_RIGHT;
                        end else if (r_y_avg < ENTER_NEG) begin
                            r_state <= ST_LEFT;
                        end
                    end
                    ST_RIGHT: begin
                        if (r_y_avg <= EXIT_POS) begin
                            r_state <= ST_FLAT;
                        end
                    end
                    ST_LEFT: begin
                        if (r_y_avg >= EXIT_NEG) begin
                            r_state <= ST_FLAT;
                        end
                    end
                    default: r_state <= ST_FLAT;
                endcase
            end
        end
    end

    assign y_avg       = r_y_avg;
    assign z_avg       = r_z_avg;
    assign avg_valid   = r_avg_valid;
    assign tilt        = r_state;
    assign upside_down = r_upside;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Scoreboard bench for accel_tilt_filter: a window/average/tilt reference model
// feeds an expected queue that a negedge monitor drains whenever avg_valid pulses.
module tb_accel_tilt_filter;

  localparam int W   = 35;
  localparam int WIN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] Y_value;
  logic [15:0] Z_value;
  logic        clear;
  logic [15:0] y_avg;
  logic [15:0] z_avg;
  logic        avg_valid;
  logic [1:0]  tilt;
  logic        upside_down;

  int checks = 0;
  int errors = 0;

  // Expected entry: {tilt[1:0], upside_down, y_avg[15:0], z_avg[15:0]}
  logic [W-1:0] exp_q[$];
  int           win_y[$];
  int           win_z[$];
  logic [1:0]   m_tilt = 2'b00;
  bit           mon_pend = 1'b0;
  logic [2:0]   mon_exp_tu = 3'b000;

  accel_tilt_filter dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .Y_value(Y_value),
    .Z_value(Z_value),
    .clear(clear),
    .y_avg(y_avg),
    .z_avg(z_avg),
    .avg_valid(avg_valid),
    .tilt(tilt),
    .upside_down(upside_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    if (s < 0 && (s % d) != 0) return s / d - 1;
    return s / d;
  endfunction

  task automatic model_reset();
    win_y.delete();
    win_z.delete();
    m_tilt = 2'b00;
  endtask

  task automatic model_push(input int y, input int z);
    int sy;
    int sz;
    int ya;
    int za;
    logic ud;
    win_y.push_back(y);
    win_z.push_back(z);
    if (win_y.size() > WIN) begin
      void'(win_y.pop_front());
      void'(win_z.pop_front());
    end
    if (win_y.size() == WIN) begin
      sy = 0;
      sz = 0;
      foreach (win_y[i]) begin
        sy += win_y[i];
        sz += win_z[i];
      end
      ya = floor_div(sy, WIN);
      za = floor_div(sz, WIN);
      case (m_tilt)
        2'b00: begin
          if (ya > 200) m_tilt = 2'b01;
          else if (ya < -200) m_tilt = 2'b10;
        end
        2'b01: if (ya <= 150) m_tilt = 2'b00;
        2'b10: if (ya >= -150) m_tilt = 2'b00;
        default: m_tilt = 2'b00;
      endcase
      ud = (za < 0);
      exp_q.push_back({m_tilt, ud, ya[15:0], za[15:0]});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] y, input logic [15:0] z);
    sample_valid = 1'b1;
    Y_value = y;
    Z_value = z;
    model_push(int'($signed(y)), int'($signed(z)));
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] y, input logic [15:0] z, input int n, input int gap);
    repeat (n) begin
      send(y, z);
      idle(gap);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_y_avg"}, y_avg, 0);
    chk({tag, "_z_avg"}, z_avg, 0);
    chk({tag, "_avg_valid"}, avg_valid, 0);
    chk({tag, "_tilt"}, tilt, 0);
    chk({tag, "_upside_down"}, upside_down, 0);
  endtask

  // Monitor: compares averages on each avg_valid pulse, then tilt/upside_down one edge later.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mon_pend) begin
          chk("tilt", tilt, mon_exp_tu[2:1]);
          chk("upside_down", upside_down, mon_exp_tu[0]);
          mon_pend = 1'b0;
        end
        if (avg_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL avg_valid: got 1 expected 0 (no full window pending) at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("y_avg", y_avg, e[31:16]);
            chk("z_avg", z_avg, e[15:0]);
            mon_exp_tu = e[34:32];
            mon_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    reset = 1'b1;
    clear = 1'b0;
    sample_valid = 1'b0;
    Y_value = '0;
    Z_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    idle(2);

    // Warm-up with gaps; nothing may emerge before the 8th sample.
    send_n(16'h0100, 16'h0040, 7, 3);
    chk("warmup_avg_valid", avg_valid, 0);
    send_n(16'h0100, 16'h0040, 1, 3);

    // Sliding window toward zero, back-to-back.
    send_n(16'h0000, 16'h0040, 8, 0);
    idle(4);

    // Negative floor and upside-down.
    send_n(16'hFFFF, 16'hFF00, 1, 3);
    send_n(16'hFFF8, 16'hFF00, 8, 0);
    idle(4);

    // Hysteresis walk.
    send_n(16'd201, 16'h0100, 8, 0);
    send_n(16'd160, 16'h0100, 8, 0);
    send_n(16'd150, 16'h0100, 8, 0);
    send_n(16'd200, 16'h0100, 8, 0);
    send_n(16'hFF37, 16'h0100, 8, 0);
    send_n(16'hFF69, 16'h0100, 8, 0);
    send_n(16'hFF6A, 16'h0100, 8, 0);
    idle(4);

    // Randomized stream with random gaps.
    repeat (150) begin
      v = int'($urandom_range(0, 900)) - 450;
      send(v[15:0], 16'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);

    // Clear together with a strobe mid-stream.
    send_n(16'd300, 16'hFF00, 8, 0);
    send_n(16'd20, 16'h0010, 3, 0);
    idle(4);
    sample_valid = 1'b1;
    clear = 1'b1;
    Y_value = 16'h7000;
    Z_value = 16'h7000;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear = 1'b0;
    model_reset();
    chk_zero("clear");
    send_n(16'h0200, 16'h0020, 7, 0);
    idle(3);
    chk("clear_refill_avg_valid", avg_valid, 0);
    send_n(16'h0200, 16'h0020, 1, 4);

    // Asynchronous reset between edges with averages in flight.
    send_n(16'd300, 16'hFF00, 8, 0);
    send_n(16'd280, 16'hFF80, 3, 0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    mon_pend = 1'b0;
    model_reset();
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_n(16'hFE00, 16'h0030, 7, 1);
    chk("reset_refill_avg_valid", avg_valid, 0);
    send_n(16'hFE00, 16'h0030, 1, 4);

    idle(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
